// File: rtl/synth_pkg.sv
// Shared types and constants for the synth parameter controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package synth_pkg;

  // Envelope phase encoding, also driven straight out on env_phase
  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4
  } env_phase_t;

  // Parameter table layout: index == nibble position inside params
  localparam int unsigned NUM_PARAMS = 5;
  localparam logic [2:0]  P_VOL      = 3'd0;
  localparam logic [2:0]  P_ATTACK   = 3'd1;
  localparam logic [2:0]  P_DECAY    = 3'd2;
  localparam logic [2:0]  P_SUSTAIN  = 3'd3;
  localparam logic [2:0]  P_RELEASE  = 3'd4;

  // Parameter values loaded by reset
  localparam logic [3:0]  VOL_RST     = 4'd15;
  localparam logic [3:0]  ATTACK_RST  = 4'd2;
  localparam logic [3:0]  DECAY_RST   = 4'd4;
  localparam logic [3:0]  SUSTAIN_RST = 4'd10;
  localparam logic [3:0]  RELEASE_RST = 4'd6;

  localparam logic [2:0]  OCT_MAX = 3'd7;

  // x*17 maps 0..15 onto 0..255; it is just the nibble repeated
  function automatic logic [7:0] scale17(input logic [3:0] v);
    return {v, v};
  endfunction

  // Per-tick envelope step: larger parameter means slower slope
  function automatic logic [7:0] step_of(input logic [3:0] v);
    return 8'd16 - {4'd0, v};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for one asynchronous level, plus rising-edge pulse.
// Latency: level valid 2 edges after input change; rise is high in the cycle after that.
// Backpressure: none; rise is a single-cycle pulse per 0->1 transition.
module sync_edge (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s2_d;

  // Metastability chain plus one delayed copy for edge detection
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s2_d;

endmodule

// File: rtl/synth_param_ctrl.sv
// Synth control: octave, five ADSR/volume params and an ADSR envelope generator.
// Latency: decoder inputs act on the 3rd CLOCK_50 edge after first being sampled high.
// Backpressure: none; every input edge is consumed, envelope steps once per tick.
module synth_param_ctrl
  import synth_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned OCT_RESET = 4
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  input  logic [3:0]  note,
  input  logic        note_in,
  input  logic        octave_minus_minus,
  input  logic        octave_plus_plus,
  input  logic        ADSR_minus_minus,
  input  logic        ADSR_plus_plus,
  input  logic [2:0]  ADSR_selector,
  output logic [3:0]  note_out,
  output logic [2:0]  octave,
  output logic [19:0] params,
  output logic        gate,
  output logic [2:0]  env_phase,
  output logic [7:0]  env_level
);

  localparam int unsigned      CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic       rst_n;
  logic [2:0] unused_key;
  assign rst_n      = KEY[0];
  assign unused_key = KEY[3:1];

  // ---------------- input synchronisers ----------------
  logic       gate_rise;
  logic       oct_up_rise;
  logic       oct_dn_rise;
  logic       adsr_up_rise;
  logic       adsr_dn_rise;
  logic [3:0] unused_lvl;

  sync_edge u_sync_gate (
    .CLOCK_50 (CLOCK_50), .rst_n (rst_n), .din (note_in),
    .level    (gate),     .rise  (gate_rise)
  );
  sync_edge u_sync_oct_up (
    .CLOCK_50 (CLOCK_50),      .rst_n (rst_n), .din (octave_plus_plus),
    .level    (unused_lvl[0]), .rise  (oct_up_rise)
  );
  sync_edge u_sync_oct_dn (
    .CLOCK_50 (CLOCK_50),      .rst_n (rst_n), .din (octave_minus_minus),
    .level    (unused_lvl[1]), .rise  (oct_dn_rise)
  );
  sync_edge u_sync_adsr_up (
    .CLOCK_50 (CLOCK_50),      .rst_n (rst_n), .din (ADSR_plus_plus),
    .level    (unused_lvl[2]), .rise  (adsr_up_rise)
  );
  sync_edge u_sync_adsr_dn (
    .CLOCK_50 (CLOCK_50),      .rst_n (rst_n), .din (ADSR_minus_minus),
    .level    (unused_lvl[3]), .rise  (adsr_dn_rise)
  );

  // Selector gets the same 2-flop delay so it lines up with the ADSR edges
  logic [2:0] sel_s1;
  logic [2:0] sel_q;

  // Selector synchroniser
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      sel_s1 <= 3'd0;
      sel_q  <= 3'd0;
    end else begin
      sel_s1 <= ADSR_selector;
      sel_q  <= sel_s1;
    end
  end

  // ---------------- octave ----------------
  logic [2:0] octave_q;

  // Saturating octave up/down; simultaneous edges cancel
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      octave_q <= 3'(OCT_RESET);
    end else if (oct_up_rise && !oct_dn_rise && octave_q != OCT_MAX) begin
      octave_q <= octave_q + 3'd1;
    end else if (oct_dn_rise && !oct_up_rise && octave_q != 3'd0) begin
      octave_q <= octave_q - 3'd1;
    end
  end

  assign octave = octave_q;

  // ---------------- parameter table ----------------
  logic [NUM_PARAMS-1:0][3:0] prm;

  // Saturating update of the selected entry; selectors 5..7 match nothing
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      prm[P_VOL]     <= VOL_RST;
      prm[P_ATTACK]  <= ATTACK_RST;
      prm[P_DECAY]   <= DECAY_RST;
      prm[P_SUSTAIN] <= SUSTAIN_RST;
      prm[P_RELEASE] <= RELEASE_RST;
    end else begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (sel_q == 3'(i)) begin
          if (adsr_up_rise && !adsr_dn_rise && prm[i] != 4'hF) begin
            prm[i] <= prm[i] + 4'd1;
          end else if (adsr_dn_rise && !adsr_up_rise && prm[i] != 4'h0) begin
            prm[i] <= prm[i] - 4'd1;
          end
        end
      end
    end
  end

  assign params = prm;

  // ---------------- tick generator ----------------
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  assign tick = (tick_cnt == CNT_LAST);

  // Free-running envelope time base, independent of envelope phase
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // ---------------- derived envelope targets ----------------
  logic [7:0] peak;
  logic [7:0] sus_raw;
  logic [7:0] sus;
  logic [7:0] step_a;
  logic [7:0] step_d;
  logic [7:0] step_r;

  assign peak    = scale17(prm[P_VOL]);
  assign sus_raw = scale17(prm[P_SUSTAIN]);
  assign sus     = (sus_raw < peak) ? sus_raw : peak;
  assign step_a  = step_of(prm[P_ATTACK]);
  assign step_d  = step_of(prm[P_DECAY]);
  assign step_r  = step_of(prm[P_RELEASE]);

  // ---------------- envelope FSM ----------------
  env_phase_t phase_q;
  env_phase_t phase_d;
  logic [7:0] level_q;
  logic [7:0] level_d;
  logic [3:0] note_q;
  logic [3:0] note_d;
  logic [8:0] att_sum;
  logic [8:0] dec_diff;
  logic [8:0] rel_diff;

  // Bit 8 of each carries overflow / borrow
  assign att_sum  = {1'b0, level_q} + {1'b0, step_a};
  assign dec_diff = {1'b0, level_q} - {1'b0, step_d};
  assign rel_diff = {1'b0, level_q} - {1'b0, step_r};

  // Envelope state register; reset aborts straight to IDLE
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      level_q <= 8'd0;
      note_q  <= 4'd0;
    end else begin
      phase_q <= phase_d;
      level_q <= level_d;
      note_q  <= note_d;
    end
  end

  // Next phase/level: gate rise beats everything, gate low forces release,
  // otherwise slopes advance only on tick
  always_comb begin
    phase_d = phase_q;
    level_d = level_q;
    note_d  = note_q;
    if (gate_rise) begin
      note_d  = note;
      phase_d = PH_ATTACK;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          level_d = 8'd0;
        end
        PH_ATTACK: begin
          if (!gate) begin
            phase_d = PH_RELEASE;
          end else if (tick) begin
            if (att_sum[8] || att_sum[7:0] >= peak) begin
              level_d = peak;
              phase_d = PH_DECAY;
            end else begin
              level_d = att_sum[7:0];
            end
          end
        end
        PH_DECAY: begin
          if (!gate) begin
            phase_d = PH_RELEASE;
          end else if (tick) begin
            if (dec_diff[8] || dec_diff[7:0] <= sus) begin
              level_d = sus;
              phase_d = PH_SUSTAIN;
            end else begin
              level_d = dec_diff[7:0];
            end
          end
        end
        PH_SUSTAIN: begin
          if (!gate) begin
            phase_d = PH_RELEASE;
          end else begin
            level_d = sus;
          end
        end
        PH_RELEASE: begin
          if (tick) begin
            if (rel_diff[8] || rel_diff[7:0] == 8'd0) begin
              level_d = 8'd0;
              phase_d = PH_IDLE;
            end else begin
              level_d = rel_diff[7:0];
            end
          end
        end
        default: begin
          phase_d = PH_IDLE;
          level_d = 8'd0;
        end
      endcase
    end
  end

  assign note_out  = note_q;
  assign env_phase = phase_q;
  assign env_level = level_q;

endmodule

// File: tb/tb_synth_param_ctrl.sv
// Directed self-checking bench for synth_param_ctrl with TICK_DIV=4.
// Latency: inputs driven on negedge, outputs sampled on negedge.
// Backpressure: n/a.
module tb_synth_param_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic [3:0]  KEY = 4'b1110;
  logic [3:0]  note = 4'd0;
  logic        note_in = 1'b0;
  logic        octave_minus_minus = 1'b0;
  logic        octave_plus_plus = 1'b0;
  logic        ADSR_minus_minus = 1'b0;
  logic        ADSR_plus_plus = 1'b0;
  logic [2:0]  ADSR_selector = 3'd0;
  logic [3:0]  note_out;
  logic [2:0]  octave;
  logic [19:0] params;
  logic        gate;
  logic [2:0]  env_phase;
  logic [7:0]  env_level;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] prev_lvl = 8'd0;

  synth_param_ctrl #(.TICK_DIV(4), .OCT_RESET(4)) dut (
    .CLOCK_50           (CLOCK_50),
    .KEY                (KEY),
    .note               (note),
    .note_in            (note_in),
    .octave_minus_minus (octave_minus_minus),
    .octave_plus_plus   (octave_plus_plus),
    .ADSR_minus_minus   (ADSR_minus_minus),
    .ADSR_plus_plus     (ADSR_plus_plus),
    .ADSR_selector      (ADSR_selector),
    .note_out           (note_out),
    .octave             (octave),
    .params             (params),
    .gate               (gate),
    .env_phase          (env_phase),
    .env_level          (env_level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic pulse(input logic op, input logic om, input logic ap, input logic am);
    @(negedge CLOCK_50);
    octave_plus_plus   = op;
    octave_minus_minus = om;
    ADSR_plus_plus     = ap;
    ADSR_minus_minus   = am;
    repeat (4) @(negedge CLOCK_50);
    octave_plus_plus   = 1'b0;
    octave_minus_minus = 1'b0;
    ADSR_plus_plus     = 1'b0;
    ADSR_minus_minus   = 1'b0;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    KEY = 4'b1110;
    @(negedge CLOCK_50);
    KEY = 4'b1111;
  endtask

  task automatic wait_change(input string nm);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 16 && !seen; c++) begin
      @(negedge CLOCK_50);
      if (env_level !== prev_lvl) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s: level stuck at %0d for 16 cycles", nm, env_level);
    end
  endtask

  task automatic wait_phase(input logic [2:0] ph, input string nm);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLOCK_50);
      if (env_phase === ph) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s: phase %0d, expected %0d within 20 cycles", nm, env_phase, ph);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLOCK_50);
    KEY = 4'b1111;
    tests++; if (octave !== 3'd4) begin fails++; $display("FAIL rst_octave: got %0d expected 4", octave); end
    tests++; if (params !== 20'h6A42F) begin fails++; $display("FAIL rst_params: got %h expected 6a42f", params); end
    tests++; if (env_phase !== 3'd0) begin fails++; $display("FAIL rst_phase: got %0d expected 0", env_phase); end
    tests++; if (env_level !== 8'd0) begin fails++; $display("FAIL rst_level: got %0d expected 0", env_level); end
    tests++; if (note_out !== 4'd0) begin fails++; $display("FAIL rst_note_out: got %0d expected 0", note_out); end
    tests++; if (gate !== 1'b0) begin fails++; $display("FAIL rst_gate: got %0d expected 0", gate); end
  endtask

  task automatic test_octave();
    logic [2:0] up_exp [5];
    logic [2:0] dn_exp [8];
    up_exp = '{3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
    dn_exp = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      tests++;
      if (octave !== up_exp[i]) begin fails++; $display("FAIL oct_up%0d: got %0d expected %0d", i, octave, up_exp[i]); end
    end
    for (int i = 0; i < 8; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      tests++;
      if (octave !== dn_exp[i]) begin fails++; $display("FAIL oct_dn%0d: got %0d expected %0d", i, octave, dn_exp[i]); end
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (octave !== 3'd1) begin fails++; $display("FAIL oct_up_from0: got %0d expected 1", octave); end
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    tests++; if (octave !== 3'd1) begin fails++; $display("FAIL oct_both: got %0d expected 1", octave); end
  endtask

  task automatic test_adsr();
    @(negedge CLOCK_50);
    ADSR_selector = 3'd1;
    repeat (3) @(negedge CLOCK_50);
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    tests++; if (params !== 20'h6A47F) begin fails++; $display("FAIL adsr_att5: got %h expected 6a47f", params); end
    for (int i = 0; i < 15; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    tests++; if (params !== 20'h6A4FF) begin fails++; $display("FAIL adsr_att_sat: got %h expected 6a4ff", params); end
    ADSR_selector = 3'd6;
    repeat (3) @(negedge CLOCK_50);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    tests++; if (params !== 20'h6A4FF) begin fails++; $display("FAIL adsr_sel6_up: got %h expected 6a4ff", params); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    tests++; if (params !== 20'h6A4FF) begin fails++; $display("FAIL adsr_sel6_dn: got %h expected 6a4ff", params); end
    ADSR_selector = 3'd0;
    repeat (3) @(negedge CLOCK_50);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    tests++; if (params !== 20'h6A4FE) begin fails++; $display("FAIL adsr_vol_dn: got %h expected 6a4fe", params); end
    ADSR_selector = 3'd4;
    repeat (3) @(negedge CLOCK_50);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    tests++; if (params !== 20'h6A4FE) begin fails++; $display("FAIL adsr_both: got %h expected 6a4fe", params); end
    for (int i = 0; i < 7; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    tests++; if (params !== 20'h0A4FE) begin fails++; $display("FAIL adsr_rel_floor: got %h expected 0a4fe", params); end
  endtask

  task automatic test_envelope();
    logic [7:0] exp_l;
    logic [2:0] exp_p;
    do_reset();
    note    = 4'd9;
    note_in = 1'b1;
    wait_phase(3'd1, "env_enter_attack");
    tests++; if (note_out !== 4'd9) begin fails++; $display("FAIL env_note_out: got %0d expected 9", note_out); end
    tests++; if (env_level !== 8'd0) begin fails++; $display("FAIL env_start_level: got %0d expected 0", env_level); end
    prev_lvl = 8'd0;
    for (int k = 1; k <= 19; k++) begin
      exp_l = (k < 19) ? 8'(14 * k) : 8'd255;
      exp_p = (k < 19) ? 3'd1 : 3'd2;
      wait_change("attack");
      tests++;
      if (env_level !== exp_l || env_phase !== exp_p) begin
        fails++;
        $display("FAIL attack_tick%0d: level %0d phase %0d, expected level %0d phase %0d", k, env_level, env_phase, exp_l, exp_p);
      end
      prev_lvl = exp_l;
    end
    for (int k = 1; k <= 8; k++) begin
      exp_l = (k < 8) ? 8'(255 - 12 * k) : 8'd170;
      exp_p = (k < 8) ? 3'd2 : 3'd3;
      wait_change("decay");
      tests++;
      if (env_level !== exp_l || env_phase !== exp_p) begin
        fails++;
        $display("FAIL decay_tick%0d: level %0d phase %0d, expected level %0d phase %0d", k, env_level, env_phase, exp_l, exp_p);
      end
      prev_lvl = exp_l;
    end
    repeat (12) @(negedge CLOCK_50);
    tests++;
    if (env_level !== 8'd170 || env_phase !== 3'd3) begin
      fails++;
      $display("FAIL sustain_hold: level %0d phase %0d, expected level 170 phase 3", env_level, env_phase);
    end
    tests++; if (gate !== 1'b1) begin fails++; $display("FAIL gate_high: got %0d expected 1", gate); end
  endtask

  task automatic test_release();
    logic [7:0] exp_l;
    logic [2:0] exp_p;
    note_in = 1'b0;
    wait_phase(3'd4, "rel_enter");
    tests++; if (env_level !== 8'd170) begin fails++; $display("FAIL rel_start_level: got %0d expected 170", env_level); end
    prev_lvl = 8'd170;
    for (int k = 1; k <= 17; k++) begin
      exp_l = (k < 17) ? 8'(170 - 10 * k) : 8'd0;
      exp_p = (k < 17) ? 3'd4 : 3'd0;
      wait_change("release");
      tests++;
      if (env_level !== exp_l || env_phase !== exp_p) begin
        fails++;
        $display("FAIL release_tick%0d: level %0d phase %0d, expected level %0d phase %0d", k, env_level, env_phase, exp_l, exp_p);
      end
      prev_lvl = exp_l;
    end
    tests++; if (gate !== 1'b0) begin fails++; $display("FAIL gate_low: got %0d expected 0", gate); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_l;
    // abort an attack with reset
    note    = 4'd3;
    note_in = 1'b1;
    wait_phase(3'd1, "mid_enter_attack");
    tests++; if (note_out !== 4'd3) begin fails++; $display("FAIL mid_note_out: got %0d expected 3", note_out); end
    prev_lvl = 8'd0;
    for (int k = 1; k <= 2; k++) begin
      exp_l = 8'(14 * k);
      wait_change("mid_attack");
      tests++; if (env_level !== exp_l) begin fails++; $display("FAIL mid_attack%0d: got %0d expected %0d", k, env_level, exp_l); end
      prev_lvl = exp_l;
    end
    KEY     = 4'b1110;
    note_in = 1'b0;
    @(negedge CLOCK_50);
    tests++;
    if (env_phase !== 3'd0 || env_level !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset: phase %0d level %0d, expected phase 0 level 0", env_phase, env_level);
    end
    tests++; if (note_out !== 4'd0) begin fails++; $display("FAIL mid_reset_note: got %0d expected 0", note_out); end
    KEY = 4'b1111;
    // re-trigger during release keeps the current level
    note_in = 1'b1;
    wait_phase(3'd1, "rt_enter_attack");
    prev_lvl = 8'd0;
    for (int k = 1; k <= 3; k++) begin
      exp_l = 8'(14 * k);
      wait_change("rt_attack");
      tests++; if (env_level !== exp_l) begin fails++; $display("FAIL rt_attack%0d: got %0d expected %0d", k, env_level, exp_l); end
      prev_lvl = exp_l;
    end
    note_in = 1'b0;
    wait_phase(3'd4, "rt_enter_release");
    tests++; if (env_level !== 8'd42) begin fails++; $display("FAIL rt_release_start: got %0d expected 42", env_level); end
    prev_lvl = 8'd42;
    wait_change("rt_release");
    tests++;
    if (env_level !== 8'd32 || env_phase !== 3'd4) begin
      fails++;
      $display("FAIL rt_release_tick: level %0d phase %0d, expected level 32 phase 4", env_level, env_phase);
    end
    note_in = 1'b1;
    wait_phase(3'd1, "rt_reattack");
    tests++; if (env_level !== 8'd32) begin fails++; $display("FAIL rt_retained: got %0d expected 32", env_level); end
    prev_lvl = 8'd32;
    wait_change("rt_reattack_tick");
    tests++;
    if (env_level !== 8'd46 || env_phase !== 3'd1) begin
      fails++;
      $display("FAIL rt_reattack_tick: level %0d phase %0d, expected level 46 phase 1", env_level, env_phase);
    end
    note_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_octave();
    test_adsr();
    test_envelope();
    test_release();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/synth_param_ctrl.md
SYNTH_PARAM_CTRL -- requirements
Module: synth_param_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, 50000, CLOCK_50 cycles per envelope tick (1 kHz).
REQ-002 SHALL have parameter OCT_RESET, 4, octave value after reset.
REQ-003 SHALL have ports in this order:
- CLOCK_50  in  1  sole clock, all logic on rising edge.
- KEY  in  4  KEY[0] is a synchronous, active-low reset. KEY[3:1] are ignored.
- note  in  4  semitone 0..11 from the keyboard decoder.
- note_in, octave_minus_minus, octave_plus_plus, ADSR_minus_minus, ADSR_plus_plus  in  1 each  asynchronous decoder levels.
- ADSR_selector  in  3  0=vol, 1=attack, 2=decay, 3=sustain, 4=release.
- note_out  out  4  note latched at gate rise.
- octave  out  3  current octave.
- params  out  20  {release,sustain,decay,attack,vol}, 4 bits each.
- gate  out  1  synchronised note_in level.
- env_phase  out  3  0=IDLE, 1=ATTACK, 2=DECAY, 3=SUSTAIN, 4=RELEASE.
- env_level  out  8  envelope amplitude.

Function
REQ-004 SHALL pass every 1-bit input through a 2-FF synchroniser and a registered rising-edge detector; one action per 0->1 transition; held-high input acts once.
REQ-005 SHALL apply an action on the 3rd CLOCK_50 edge after the input is first sampled high.
REQ-006 SHALL increment octave on octave_plus_plus edge, saturating at 7; SHALL decrement on octave_minus_minus edge, saturating at 0; both edges in the same cycle -> no change.
REQ-007 SHALL hold five 4-bit params; an ADSR_plus_plus/ADSR_minus_minus edge updates the entry indexed by synchronised ADSR_selector, saturating at 15 and 0.
- Selector 5..7 -> no change.
- Both edges in the same cycle -> no change.
REQ-008 SHALL run a tick counter 0..TICK_DIV-1 that produces a 1-cycle tick on wrap; the counter free-runs independent of envelope state.
REQ-009 Derived values, 8-bit, computed combinationally from current params:
- peak = vol*17.
- sus = min(sustain*17, peak).
- step_x = 16 - x for x in attack/decay/release.
REQ-010 On gate rise, in any state: note_out <= note, env_phase <= ATTACK, env_level retained (no reset to 0).
REQ-011 ATTACK, on tick: level += step_a; if result >= peak or overflows 255 -> level = peak, go to DECAY.
REQ-012 DECAY, on tick: level -= step_d; if result <= sus or underflows -> level = sus, go to SUSTAIN.
REQ-013 SUSTAIN: level = sus every cycle, so live param changes are tracked.
REQ-014 Gate fall in ATTACK, DECAY or SUSTAIN -> RELEASE on the next edge.
REQ-015 RELEASE, on tick: level -= step_r, floor 0; at 0 -> IDLE.
REQ-016 Gate rise and gate fall in the same cycle is impossible after sync; gate rise wins over a tick in the same cycle.
REQ-017 Param changes during ATTACK, DECAY or RELEASE SHALL take effect on the next tick; vol=0 gives peak=0, so ATTACK exits to DECAY on the first tick.
REQ-018 IDLE: env_level = 0.

Reset
REQ-019 KEY[0]=0 at a rising edge SHALL set all outputs and state on that edge:
- octave=OCT_RESET; params vol=15, attack=2, decay=4, sustain=10, release=6.
- env_phase=IDLE, env_level=0, note_out=0, gate=0.
- Tick counter, synchronisers and edge registers cleared.
REQ-020 Reset mid-envelope SHALL abort to IDLE with no release.

Structure
REQ-021 Package synth_pkg SHALL hold the phase encoding, the param index constants and the param reset values.
REQ-022 Sub-module sync_edge (2-FF sync plus rise output) SHALL be instantiated once per 1-bit input.

Verification (TICK_DIV=4)
REQ-023 Reset pulse -> octave=4, params=20'h6A42F, env_phase=0, env_level=0.
REQ-024 Five octave_plus_plus pulses -> octave 7; then eight octave_minus_minus pulses -> 0; simultaneous plus/minus -> unchanged.
REQ-025 ADSR_selector=1 with 20 ADSR_plus_plus pulses -> attack=15; selector=6 with plus pulse -> params unchanged.
REQ-026 note=9, note_in held high -> note_out=9, then:
- ATTACK reaches 255 on the 19th tick.
- DECAY reaches 170 on the 8th tick, then SUSTAIN at 170.
REQ-027 note_in low in SUSTAIN -> RELEASE, 170 to 0 in 17 ticks, then IDLE.
REQ-028 KEY[0]=0 during ATTACK -> next edge env_phase=0, env_level=0; note_in re-rise in RELEASE -> ATTACK from the current level.
